prng_sample_fifo: RTL and testbench
===================================

PRNG_SAMPLE_FIFO -- requirements
Module: prng_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes (power of two, 2..16).
REQ-002 SHALL have parameter REP_LIMIT, default 4, meaning consecutive identical samples that trip the health test (2..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  block enable; when low, no state changes except reset.
REQ-006 SHALL have port in_data  input  8  random byte from the upstream PRNG.
REQ-007 SHALL have port in_valid  input  1  in_data carries a new sample this cycle.
REQ-008 SHALL have port out_data  output  8  head-of-FIFO byte.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data when out_valid is high.
REQ-011 SHALL have port level  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port drop_cnt  output  8  samples lost to a full FIFO, saturating at 255.
REQ-013 SHALL have port rep_fail  output  1  sticky repetition-test failure flag.
REQ-014 SHALL have port clr_fail  input  1  synchronous clear of rep_fail and the run counter.

Function
REQ-015 Sample event SHALL be ena & in_valid; pop event SHALL be ena & out_valid & out_ready.
REQ-016 FIFO SHALL be first-word-fall-through: out_data is valid combinationally from storage whenever out_valid=1.
REQ-017 A byte pushed at edge N SHALL be visible on out_data/out_valid after edge N (latency 1).
REQ-018 Push SHALL be accepted when sample event & ~rep_fail & (level<DEPTH or pop event same cycle).
REQ-019 Simultaneous push and pop SHALL leave level unchanged; when full, the popped slot is reused.
REQ-020 Pop when empty SHALL be impossible because out_valid=0; read pointer unchanged.
REQ-021 A sample event that is refused only because the FIFO is full SHALL increment drop_cnt by 1; drop_cnt SHALL hold at 255.
REQ-022 Read/write pointers SHALL be log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal.
REQ-023 Health test SHALL examine every sample event, including those later dropped or gated.
REQ-024 Health test SHALL track last byte (prev) and run length (run, 4 bits); the first sample after reset or clr_fail sets run=1.
REQ-025 For a subsequent sample, in_data==prev SHALL set run=run+1 (saturate 15); otherwise run=1. prev SHALL always load in_data.
REQ-026 rep_fail SHALL set on the edge where run becomes REP_LIMIT; the tripping sample itself SHALL NOT be pushed.
REQ-027 While rep_fail=1, pushes SHALL be blocked, the FIFO SHALL keep draining normally, and drop_cnt SHALL NOT count gated samples.
REQ-028 clr_fail (with ena) SHALL clear rep_fail, set the run state to "first", and take priority over a same-cycle trip.

Reset
REQ-029 rst_n low SHALL asynchronously force: pointers 0, level 0, out_valid 0, drop_cnt 0, rep_fail 0, prev 0x00, run state "first".
REQ-030 out_data SHALL read 0x00 during reset (storage cleared).
REQ-031 Reset mid-operation SHALL discard all buffered bytes; no pop completes in the reset cycle.

Structure
REQ-032 Package prng_pkg SHALL hold the byte typedef and the default values of DEPTH and REP_LIMIT.
REQ-033 The health test SHALL be one sub-module, prng_rep_test (inputs: sample, data, clr; outputs: trip, fail); storage and pointers stay in the top.

Verification
REQ-034 Reset, then push 0x11,0x22,0x33 with out_ready=0 -> level=3, out_data=0x11; then hold out_ready=1 for 3 cycles -> 0x11,0x22,0x33 emitted, out_valid=0, level=0.
REQ-035 Push 10 distinct bytes with DEPTH=8 and out_ready=0 -> level=8, drop_cnt=2, out_data equals first byte.
REQ-036 With FIFO full, push and pop in the same cycle -> level stays 8, new byte lands at tail, drop_cnt unchanged.
REQ-037 Feed 0xA5 four times -> rep_fail=1 on the 4th edge, only 3 bytes stored; then 0x3C -> not stored, drop_cnt unchanged; clr_fail, then 0x3C -> stored.
REQ-038 Fill FIFO with 5 bytes, pulse rst_n low asynchronously mid-cycle -> out_valid=0, level=0, drop_cnt=0, rep_fail=0 immediately.
REQ-039 Push 300 samples into a full FIFO -> drop_cnt saturates at 255; ena=0 for 5 cycles with in_valid=1 -> no state change.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and default sizing for the PRNG sample FIFO and its health test.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prng_pkg;

  typedef logic [7:0] byte_t;

  localparam int DEPTH_DEF     = 8;
  localparam int REP_LIMIT_DEF = 4;

  // Run-length counter saturates here so a stuck source cannot wrap it.
  localparam logic [3:0] RUN_MAX = 4'd15;

endpackage

// File: rtl/prng_rep_test.sv
// Repetition-count health test: flags a source repeating the same byte REP_LIMIT times.
// Latency: trip is combinational on the sample; fail is registered on the tripping edge.
// Backpressure: none; every sample presented is examined regardless of downstream state.
module prng_rep_test
  import prng_pkg::*;
#(
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  sample,
  input  byte_t data,
  input  logic  clr,
  output logic  trip,
  output logic  fail
);

  localparam logic [3:0] LIMIT = 4'(REP_LIMIT);

  logic       first_q;
  byte_t      prev_q;
  logic [3:0] run_q;
  logic [3:0] run_d;
  logic       fail_q;

  // Run length this sample would produce: restarts at 1 after reset/clear or on a new value.
  always_comb begin
    run_d = 4'd1;
    if (!first_q && (data == prev_q)) begin
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
    end
  end

  // A clear in the same cycle wins over a trip, so the sample is not treated as failing.
  assign trip = sample & ~clr & (run_d == LIMIT);
  assign fail = fail_q;

  // Track previous byte, run length and the sticky failure flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      prev_q  <= '0;
      run_q   <= '0;
      fail_q  <= 1'b0;
    end else if (clr) begin
      first_q <= 1'b1;
      run_q   <= '0;
      fail_q  <= 1'b0;
      if (sample) begin
        prev_q <= data;
      end
    end else if (sample) begin
      first_q <= 1'b0;
      prev_q  <= data;
      run_q   <= run_d;
      if (trip) begin
        fail_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_sample_fifo.sv
// Buffers PRNG bytes in a first-word-fall-through FIFO, gated by a repetition health test.
// Latency: a byte accepted at edge N is on out_data/out_valid right after edge N.
// Backpressure: upstream cannot be stalled; samples arriving to a full FIFO are dropped and counted.
module prng_sample_fifo
  import prng_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] level,
  output logic [7:0] drop_cnt,
  output logic       rep_fail,
  input  logic       clr_fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  byte_t          mem_q [DEPTH];
  logic  [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic  [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic  [PW-1:0] occ;
  logic  [7:0]    drop_q, drop_d;

  logic sample, clr, pop, push, drop;
  logic full, empty;
  logic trip, fail;

  assign sample = ena & in_valid;
  assign clr    = ena & clr_fail;

  // Health test sees every sample, including ones later refused.
  prng_rep_test #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rep (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (sample),
    .data   (in_data),
    .clr    (clr),
    .trip   (trip),
    .fail   (fail)
  );

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign occ   = wr_ptr_q - rd_ptr_q;

  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign level     = 5'(occ);
  assign drop_cnt  = drop_q;
  assign rep_fail  = fail;

  // A full FIFO still accepts when the head leaves the same cycle; the freed slot is reused.
  assign pop  = ena & ~empty & out_ready;
  assign push = sample & ~fail & ~trip & (~full | pop);
  assign drop = sample & ~fail & ~trip & full & ~pop;

  // Next-state pointers and saturating drop counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is cleared on reset so out_data reads zero while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_prng_sample_fifo.sv
// Self-checking bench for prng_sample_fifo against a queue-based reference model.
// Latency: model updates on each rising edge, outputs compared mid-cycle.
// Backpressure: out_ready driven directly by directed steps and random stimulus.
module tb_prng_sample_fifo;

  localparam int DEPTH = 8;
  localparam int REP   = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic [7:0] drop_cnt;
  logic       rep_fail;
  logic       clr_fail;

  int n_cmp;
  int n_bad;

  // Reference model state
  logic [7:0] mq[$];
  int         m_drop;
  bit         m_fail;
  bit         m_first;
  int         m_run;
  logic [7:0] m_prev;

  prng_sample_fifo #(
    .DEPTH     (DEPTH),
    .REP_LIMIT (REP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .rep_fail  (rep_fail),
    .clr_fail  (clr_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_drop  = 0;
    m_fail  = 0;
    m_first = 1;
    m_run   = 0;
    m_prev  = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    check({tag, ".level"},     32'(level),     32'(mq.size()));
    check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drop));
    check({tag, ".rep_fail"},  32'(rep_fail),  32'(m_fail));
    if (mq.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(mq[0]));
  endtask

  // One clock cycle: drive, compare before the edge, then advance the model.
  task automatic cycle(input bit e, input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                       input string tag);
    bit sample, pop, c, trip, ok;
    int run_n;
    ena = e; in_valid = v; in_data = d; out_ready = rdy; clr_fail = clr;
    #2;
    check_outputs(tag);
    @(posedge clk);
    sample = e && v;
    c      = e && clr;
    pop    = e && rdy && (mq.size() != 0);
    trip   = 0;
    run_n  = 1;
    if (sample) begin
      if (!m_first && d == m_prev) run_n = (m_run >= 15) ? 15 : m_run + 1;
      trip = !c && (run_n == REP);
    end
    ok = sample && !m_fail && !trip;
    if (pop) void'(mq.pop_front());
    if (ok) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else if (m_drop < 255) m_drop++;
    end
    if (c) begin
      m_fail  = 0;
      m_first = 1;
      if (sample) m_prev = d;
    end else if (sample) begin
      m_prev  = d;
      m_run   = run_n;
      m_first = 0;
      if (trip) m_fail = 1;
    end
    #1;
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".level"},     32'(level),     32'd0);
    check({tag, ".drop_cnt"},  32'(drop_cnt),  32'd0);
    check({tag, ".rep_fail"},  32'(rep_fail),  32'd0);
    check({tag, ".out_data"},  32'(out_data),  32'd0);
    ena = 0; in_valid = 0; out_ready = 1; clr_fail = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; ena = 0; in_valid = 0; in_data = 0; out_ready = 0; clr_fail = 0;
    model_clear();
    #2;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.level",     32'(level),     32'd0);
    check("reset.out_data",  32'(out_data),  32'd0);
    check("reset.drop_cnt",  32'(drop_cnt),  32'd0);
    check("reset.rep_fail",  32'(rep_fail),  32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three pushes held, then drained in order.
    cycle(1, 1, 8'h11, 0, 0, "p3a");
    cycle(1, 1, 8'h22, 0, 0, "p3b");
    cycle(1, 1, 8'h33, 0, 0, "p3c");
    #2;
    check("p3.level", 32'(level), 32'd3);
    check("p3.head",  32'(out_data), 32'h11);
    #1;
    cycle(1, 0, 8'h00, 1, 0, "drain1");
    cycle(1, 0, 8'h00, 1, 0, "drain2");
    cycle(1, 0, 8'h00, 1, 0, "drain3");
    #2;
    check("drained.out_valid", 32'(out_valid), 32'd0);
    check("drained.level",     32'(level),     32'd0);
    #1;

    // Overfill by two.
    for (int i = 0; i < 10; i++) cycle(1, 1, 8'h40 + 8'(i), 0, 0, "fill10");
    #2;
    check("fill10.level", 32'(level),    32'd8);
    check("fill10.drop",  32'(drop_cnt), 32'd2);
    check("fill10.head",  32'(out_data), 32'h40);
    #1;

    // Full: push and pop together reuse the freed slot.
    cycle(1, 1, 8'h77, 1, 0, "fullpp");
    #2;
    check("fullpp.level", 32'(level),    32'd8);
    check("fullpp.drop",  32'(drop_cnt), 32'd2);
    check("fullpp.head",  32'(out_data), 32'h41);
    #1;
    for (int i = 0; i < 7; i++) cycle(1, 0, 8'h00, 1, 0, "drain7");
    #2;
    check("tail.out_data", 32'(out_data), 32'h77);
    #1;
    cycle(1, 0, 8'h00, 1, 0, "drainlast");

    // Repetition trip, gated sample, clear, accepted sample.
    for (int i = 0; i < 4; i++) cycle(1, 1, 8'hA5, 0, 0, "rep");
    #2;
    check("rep.rep_fail", 32'(rep_fail), 32'd1);
    check("rep.level",    32'(level),    32'd3);
    #1;
    cycle(1, 1, 8'h3C, 0, 0, "gated");
    #2;
    check("gated.level", 32'(level),    32'd3);
    check("gated.drop",  32'(drop_cnt), 32'd2);
    #1;
    cycle(1, 0, 8'h00, 0, 1, "clr");
    cycle(1, 1, 8'h3C, 0, 0, "afterclr");
    #2;
    check("afterclr.level",    32'(level),    32'd4);
    check("afterclr.rep_fail", 32'(rep_fail), 32'd0);
    #1;

    // Five buffered, then asynchronous reset mid-cycle.
    cycle(1, 1, 8'h55, 0, 0, "fill5");
    #2;
    check("fill5.level", 32'(level), 32'd5);
    #1;
    async_reset("midrst");

    // Drop counter saturation, then disabled cycles freeze state.
    for (int i = 0; i < 308; i++) cycle(1, 1, 8'(i), 0, 0, "sat");
    #2;
    check("sat.drop",  32'(drop_cnt), 32'd255);
    check("sat.level", 32'(level),    32'd8);
    #1;
    for (int i = 0; i < 5; i++) cycle(0, 1, 8'hEE, 1, 1, "ena0");
    #2;
    check("ena0.level", 32'(level),    32'd8);
    check("ena0.drop",  32'(drop_cnt), 32'd255);
    check("ena0.head",  32'(out_data), 32'h00);
    #1;

    // Randomized traffic with a small data alphabet to provoke repetitions.
    async_reset("rndrst");
    for (int i = 0; i < 800; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
      cycle(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1, d,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rnd");
    end
    #2;
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
